// File: rtl/rvb_shifter_arb.sv
// Two-port round-robin front end for one shared rvb_shifter. Adds no cycles on request or response.
// Backpressure: issue stalls when the tag FIFO is full or the shifter is not ready; a stalled owner stalls the shifter output.

module rvb_shifter_arb_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module rvb_shifter_arb #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*XLEN-1:0] req_rs1,
  input  logic [2*XLEN-1:0] req_rs2,
  input  logic [2*XLEN-1:0] req_rs3,
  input  logic [11:0]       req_insn,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [XLEN-1:0]   rsp_rd,
  output logic              sh_din_valid,
  input  logic              sh_din_ready,
  output logic [XLEN-1:0]   sh_din_rs1,
  output logic [XLEN-1:0]   sh_din_rs2,
  output logic [XLEN-1:0]   sh_din_rs3,
  output logic [5:0]        sh_din_insn,
  input  logic              sh_dout_valid,
  output logic              sh_dout_ready,
  input  logic [XLEN-1:0]   sh_dout_rd,
  output logic              busy,
  output logic              err
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] rs3;
    logic [5:0]      insn;
  } op_t;

  op_t         op_p0;
  op_t         op_p1;
  op_t         op_sel;
  logic        rr_last;
  logic        grant;
  logic        any_req;
  logic        can_issue;
  logic        issue;
  logic        retire;
  logic        in_flight;
  logic [0:0]  head_tag;
  logic        head;
  logic [AW:0] count;

  assign op_p0 = {req_rs1[0 +: XLEN], req_rs2[0 +: XLEN], req_rs3[0 +: XLEN], req_insn[0 +: 6]};
  assign op_p1 = {req_rs1[XLEN +: XLEN], req_rs2[XLEN +: XLEN], req_rs3[XLEN +: XLEN], req_insn[6 +: 6]};

  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~rr_last;
      default: grant = 1'b0;
    endcase
  end

  assign op_sel      = grant ? op_p1 : op_p0;
  assign sh_din_rs1  = op_sel.rs1;
  assign sh_din_rs2  = op_sel.rs2;
  assign sh_din_rs3  = op_sel.rs3;
  assign sh_din_insn = op_sel.insn;

  // Gating with reset keeps every handshake output low while reset is held.
  assign any_req      = |req_valid;
  assign can_issue    = ~reset & (count < (AW+1)'(DEPTH));
  assign sh_din_valid = can_issue & any_req;
  assign issue        = sh_din_valid & sh_din_ready;

  always_comb begin
    req_ready = 2'b00;
    if (issue) req_ready[grant] = 1'b1;
  end

  assign head          = head_tag[0];
  assign in_flight     = (count != '0);
  assign sh_dout_ready = in_flight & rsp_ready[head];
  assign retire        = sh_dout_valid & sh_dout_ready;
  assign rsp_rd        = sh_dout_rd;
  assign busy          = in_flight;

  always_comb begin
    rsp_valid = 2'b00;
    if (sh_dout_valid & in_flight) rsp_valid[head] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_last <= 1'b1;
      err     <= 1'b0;
    end else begin
      if (issue) rr_last <= grant;
      if (sh_dout_valid & ~in_flight) err <= 1'b1;
    end
  end

  rvb_shifter_arb_fifo #(
    .W     (1),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (issue),
    .push_dat (grant),
    .pop      (retire),
    .head_dat (head_tag),
    .count    (count)
  );
endmodule

// File: tb/tb_rvb_shifter_arb.sv
// Bench for rvb_shifter_arb: reference arbiter model, scoreboard of owner tags, and a queue-based shifter stand-in.
module tb_rvb_shifter_arb;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*XLEN-1:0] req_rs1;
  logic [2*XLEN-1:0] req_rs2;
  logic [2*XLEN-1:0] req_rs3;
  logic [11:0]       req_insn;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [XLEN-1:0]   rsp_rd;
  logic              sh_din_valid;
  logic              sh_din_ready;
  logic [XLEN-1:0]   sh_din_rs1;
  logic [XLEN-1:0]   sh_din_rs2;
  logic [XLEN-1:0]   sh_din_rs3;
  logic [5:0]        sh_din_insn;
  logic              sh_dout_valid;
  logic              sh_dout_ready;
  logic [XLEN-1:0]   sh_dout_rd;
  logic              busy;
  logic              err;

  rvb_shifter_arb #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3), .req_insn(req_insn),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
    .sh_din_valid(sh_din_valid), .sh_din_ready(sh_din_ready),
    .sh_din_rs1(sh_din_rs1), .sh_din_rs2(sh_din_rs2), .sh_din_rs3(sh_din_rs3),
    .sh_din_insn(sh_din_insn),
    .sh_dout_valid(sh_dout_valid), .sh_dout_ready(sh_dout_ready), .sh_dout_rd(sh_dout_rd),
    .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic            port;
    logic [XLEN-1:0] rd;
  } sb_t;

  typedef struct {
    logic [1:0] rv;
    logic       dr;
    logic       dv;
    logic [1:0] rr;
    logic       bsy;
  } vec_t;

  sb_t             sb[$];
  logic [XLEN-1:0] shq[$];
  vec_t            tbl[8];

  int   checks = 0;
  int   errors = 0;
  int   n_rsp[2];
  bit   m_rr, m_err;
  bit   sh_en, force_dv, rand_ops;
  bit   h_en, h2_en;
  logic h_dv, h_busy, h_dr;
  logic [1:0] h_rr, h_rv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] shf(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                          input logic [XLEN-1:0] c, input logic [5:0] i);
    return a ^ (b << 1) ^ {c[15:0], c[31:16]} ^ {26'd0, i};
  endfunction

  // One clock: called at posedge+1, checks at negedge, returns at the next posedge+1.
  task automatic cycle();
    logic m_any, m_can, m_g, m_dv, m_head, m_drdy, m_issue, m_ret, m_perr, e_issue, e_ret;
    logic [1:0] m_rrdy, m_rv;
    logic [XLEN-1:0] x1, x2, x3, e_dat;
    logic [5:0] xi;
    if (rand_ops) begin
      req_rs1  = {$urandom, $urandom};
      req_rs2  = {$urandom, $urandom};
      req_rs3  = {$urandom, $urandom};
      req_insn = 12'($urandom);
    end
    sh_dout_valid = force_dv | (sh_en && shq.size() > 0);
    sh_dout_rd    = (shq.size() > 0) ? shq[0] : XLEN'($urandom);
    @(negedge clock);
    m_any  = |req_valid;
    m_can  = sb.size() < DEPTH;
    m_g    = (req_valid == 2'b10) ? 1'b1 : (req_valid == 2'b11) ? !m_rr : 1'b0;
    m_dv   = m_can && m_any;
    m_issue = m_dv && sh_din_ready;
    m_rrdy = m_issue ? (m_g ? 2'b10 : 2'b01) : 2'b00;
    m_head = (sb.size() > 0) ? sb[0].port : 1'b0;
    m_drdy = (sb.size() > 0) && rsp_ready[m_head];
    m_rv   = (sh_dout_valid && sb.size() > 0) ? (m_head ? 2'b10 : 2'b01) : 2'b00;
    m_ret  = sh_dout_valid && m_drdy;
    m_perr = sh_dout_valid && sb.size() == 0;
    x1 = m_g ? req_rs1[XLEN +: XLEN] : req_rs1[0 +: XLEN];
    x2 = m_g ? req_rs2[XLEN +: XLEN] : req_rs2[0 +: XLEN];
    x3 = m_g ? req_rs3[XLEN +: XLEN] : req_rs3[0 +: XLEN];
    xi = m_g ? req_insn[6 +: 6] : req_insn[0 +: 6];

    chk("din_valid", sh_din_valid, m_dv);
    chk("req_ready", req_ready, m_rrdy);
    chk("rsp_valid", rsp_valid, m_rv);
    chk("dout_ready", sh_dout_ready, m_drdy);
    chk("busy", busy, sb.size() != 0);
    chk("err", err, m_err);
    if (m_dv) begin
      chk("din_rs1", sh_din_rs1, x1);
      chk("din_rs2", sh_din_rs2, x2);
      chk("din_rs3", sh_din_rs3, x3);
      chk("din_insn", sh_din_insn, xi);
    end
    if (h_en) begin
      chk("hand_dv", sh_din_valid, h_dv);
      chk("hand_req_ready", req_ready, h_rr);
      chk("hand_busy", busy, h_busy);
    end
    if (h2_en) begin
      chk("hand_dout_ready", sh_dout_ready, h_dr);
      chk("hand_rsp_valid", rsp_valid, h_rv);
    end
    if (m_ret) begin
      chk("rsp_rd", rsp_rd, sb[0].rd);
      void'(sb.pop_front());
    end
    if (m_issue) begin
      sb.push_back('{port: m_g, rd: shf(x1, x2, x3, xi)});
      m_rr = m_g;
    end
    if (m_perr) m_err = 1'b1;
    for (int p = 0; p < 2; p++)
      if (rsp_valid[p] && rsp_ready[p]) n_rsp[p]++;

    // Shifter stand-in reacts to what the DUT actually drives.
    e_issue = sh_din_valid & sh_din_ready;
    e_ret   = sh_dout_valid & sh_dout_ready;
    e_dat   = shf(sh_din_rs1, sh_din_rs2, sh_din_rs3, sh_din_insn);
    if (e_ret && shq.size() > 0) void'(shq.pop_front());
    if (e_issue) shq.push_back(e_dat);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int dly);
    #(dly);
    reset = 1'b1;
    #1;
    chk("rst_din_valid", sh_din_valid, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_dout_ready", sh_dout_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    sb.delete();
    shq.delete();
    m_rr = 1'b1;
    m_err = 1'b0;
    sh_dout_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    h_en = 0;
    h2_en = 0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    sh_en = 1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) cycle();
    chk("drain_empty", sb.size(), 0);
    chk("drain_busy", busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req_valid = 2'b11; rsp_ready = 2'b11; sh_din_ready = 1'b1;
    sh_dout_valid = 1'b0; sh_dout_rd = '0;
    req_rs1 = '0; req_rs2 = '0; req_rs3 = '0; req_insn = '0;
    sh_en = 0; force_dv = 0; rand_ops = 1; h_en = 0; h2_en = 0;
    h_dv = 0; h_rr = 0; h_busy = 0; h_dr = 0; h_rv = 0;
    n_rsp[0] = 0; n_rsp[1] = 0;
    @(posedge clock); #1;
    do_reset(0);

    // Table: arbitration and fill from reset with the shifter output held off.
    tbl[0] = '{rv: 2'b11, dr: 1'b0, dv: 1'b1, rr: 2'b00, bsy: 1'b0};
    tbl[1] = '{rv: 2'b11, dr: 1'b1, dv: 1'b1, rr: 2'b01, bsy: 1'b0};
    tbl[2] = '{rv: 2'b11, dr: 1'b1, dv: 1'b1, rr: 2'b10, bsy: 1'b1};
    tbl[3] = '{rv: 2'b10, dr: 1'b1, dv: 1'b1, rr: 2'b10, bsy: 1'b1};
    tbl[4] = '{rv: 2'b11, dr: 1'b0, dv: 1'b1, rr: 2'b00, bsy: 1'b1};
    tbl[5] = '{rv: 2'b01, dr: 1'b1, dv: 1'b1, rr: 2'b01, bsy: 1'b1};
    tbl[6] = '{rv: 2'b11, dr: 1'b1, dv: 1'b0, rr: 2'b00, bsy: 1'b1};
    tbl[7] = '{rv: 2'b00, dr: 1'b1, dv: 1'b0, rr: 2'b00, bsy: 1'b1};
    sh_en = 0;
    h_en = 1;
    for (int i = 0; i < 8; i++) begin
      req_valid = tbl[i].rv; sh_din_ready = tbl[i].dr;
      h_dv = tbl[i].dv; h_rr = tbl[i].rr; h_busy = tbl[i].bsy;
      cycle();
    end
    // Full: a retire does not free a slot in the same cycle.
    req_valid = 2'b01; sh_din_ready = 1'b1; sh_en = 1;
    h_dv = 0; h_rr = 2'b00; h_busy = 1;
    cycle();
    sh_en = 0;
    h_dv = 1; h_rr = 2'b01; h_busy = 1;
    cycle();
    drain();

    // Single port: three ops from port 0.
    do_reset(0);
    n_rsp[0] = 0; n_rsp[1] = 0;
    rand_ops = 0;
    req_rs2 = {32'h0, 32'h0000_0011}; req_rs3 = {32'h0, 32'h0000_2200}; req_insn = 12'o0012;
    sh_en = 1; sh_din_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      req_rs1 = {32'hDEAD_BEEF, 32'(i)};
      req_valid = 2'b01;
      cycle();
    end
    drain();
    chk("single_p0_count", n_rsp[0], 3);
    chk("single_p1_count", n_rsp[1], 0);
    rand_ops = 1;
    req_valid = 2'b11; sh_din_ready = 1;
    h_en = 1; h_dv = 1; h_rr = 2'b10; h_busy = 0;
    cycle();
    drain();

    // Contention: both ports for 8 cycles, 1-cycle shifter.
    do_reset(0);
    n_rsp[0] = 0; n_rsp[1] = 0;
    sh_en = 1; sh_din_ready = 1; req_valid = 2'b11; h_en = 1;
    for (int i = 0; i < 8; i++) begin
      h_dv = 1; h_rr = (i % 2) ? 2'b10 : 2'b01; h_busy = (i != 0);
      cycle();
    end
    drain();
    chk("cont_p0_count", n_rsp[0], 4);
    chk("cont_p1_count", n_rsp[1], 4);

    // Owner back-pressure: port 1 heads the FIFO and stalls for 5 cycles.
    do_reset(0);
    n_rsp[0] = 0; n_rsp[1] = 0;
    sh_en = 0; sh_din_ready = 1;
    req_valid = 2'b10; cycle();
    req_valid = 2'b01; cycle();
    req_valid = 2'b00; rsp_ready = 2'b01; sh_en = 1;
    h2_en = 1; h_dr = 0; h_rv = 2'b10;
    for (int i = 0; i < 5; i++) cycle();
    h2_en = 0;
    rsp_ready = 2'b11;
    h2_en = 1; h_dr = 1; h_rv = 2'b10;
    cycle();
    h2_en = 0;
    drain();
    chk("bp_p1_count", n_rsp[1], 1);
    chk("bp_p0_count", n_rsp[0], 1);

    // Protocol error: result with nothing in flight.
    force_dv = 1; h2_en = 1; h_dr = 0; h_rv = 2'b00;
    cycle();
    force_dv = 0; h2_en = 0; sh_en = 0;
    chk("err_set", err, 1'b1);
    for (int i = 0; i < 3; i++) cycle();
    chk("err_sticky", err, 1'b1);

    // Mid-operation reset with two ops in flight.
    req_valid = 2'b01; sh_din_ready = 1;
    cycle(); cycle();
    req_valid = 2'b00;
    chk("pre_rst_busy", busy, 1'b1);
    do_reset(2);
    req_valid = 2'b11; sh_din_ready = 1;
    h_en = 1; h_dv = 1; h_rr = 2'b01; h_busy = 0;
    cycle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rvb_shifter_arb.md
Name: rvb_shifter_arb

Overview:
- Shares one rvb_shifter instance between two requester ports, e.g. two issue slots or two harts.
- Each cycle, a round-robin arbiter picks one requester and forwards its operands and instruction bits to the shifter's din handshake.
- A tag FIFO records which port owns each in-flight operation, so shifter results are returned in order to the owning port.
- The block sits between the issue stage and rvb_shifter. It adds no latency on the request or the response path.

Parameters:
- XLEN, 32, operand and result width (32 or 64).
- DEPTH, 4, maximum operations in flight inside the shifter. Sets the tag FIFO depth and must be a power of 2, at least 2.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit n belongs to port n.
- req_ready  out  2  per-port request accepted this cycle.
- req_rs1  in  2*XLEN  per-port rs1; port n uses bits [n*XLEN +: XLEN]. Same packing for rs2 and rs3.
- req_rs2  in  2*XLEN  per-port rs2.
- req_rs3  in  2*XLEN  per-port rs3.
- req_insn  in  2*6  per-port instruction bits {insn30,insn29,insn27,insn26,insn14,insn3}.
- rsp_valid  out  2  per-port result valid.
- rsp_ready  in  2  per-port result ready.
- rsp_rd  out  XLEN  result value, shared by both ports; qualified by rsp_valid.
- sh_din_valid  out  1  to shifter din_valid.
- sh_din_ready  in  1  from shifter din_ready.
- sh_din_rs1 / sh_din_rs2 / sh_din_rs3  out  XLEN each  to shifter operands.
- sh_din_insn  out  6  to shifter insn bits, same packing as req_insn.
- sh_dout_valid  in  1  from shifter dout_valid.
- sh_dout_ready  out  1  to shifter dout_ready.
- sh_dout_rd  in  XLEN  from shifter dout_rd.
- busy  out  1  at least one operation in flight (count != 0).
- err  out  1  sticky: set when the shifter returns a result with no operation in flight.

Behaviour:
- Reset: count=0, rr_last=1 (port 0 has priority first), err=0. All outputs derived from state are 0 while reset is high: sh_din_valid, sh_dout_ready, req_ready, rsp_valid, busy, err.
- Reset asserted mid-operation: in-flight tags are discarded and the shifter is assumed reset on the same signal. No responses are delivered for discarded operations.
- can_issue = (count < DEPTH). No bypass: a push is refused when full, even if a pop happens in the same cycle.
- Grant selection is combinational:
  - If only one req_valid bit is set, that port wins.
  - If both are set, the port != rr_last wins.
  - If neither is set, there is no grant.
- sh_din_valid = can_issue & (any req_valid). Operand and insn muxes follow the grant.
  - With no grant, sh_din_* data holds port 0's values; this is don't-care.
- req_ready[g] = can_issue & sh_din_ready for the granted port g. The losing port sees req_ready=0.
- Issue fires when sh_din_valid & sh_din_ready. On issue: push g into the tag FIFO, count+1, rr_last<=g.
- Response routing:
  - head = FIFO head tag.
  - rsp_valid[head] = sh_dout_valid & (count != 0); the other rsp_valid bit is 0.
  - rsp_rd = sh_dout_rd, passed straight through.
  - sh_dout_ready = (count != 0) & rsp_ready[head]. An owner stall back-pressures the shifter; the other port's response is never reordered ahead.
- Retire fires when sh_dout_valid & sh_dout_ready. On retire: pop, count-1.
- Issue and retire in the same cycle: count is unchanged, and read/write pointers both advance modulo DEPTH.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Error case, sh_dout_valid with count==0:
  - sh_dout_ready=0 and no rsp_valid.
  - err<=1, cleared only by reset.
- rr_last updates only on issue. A stalled grant (sh_din_ready=0) keeps the same winner on the next cycle if requests are unchanged.
- Latency: 0 cycles added on the request and response paths. Throughput is 1 op/cycle when the shifter allows it.

Test Plan:
- Single port: port 0 sends 3 ops (rs1=0x1,0x2,0x3), port 1 idle, 1-cycle shifter model -> rsp_valid[0] fires 3 times in order, rsp_valid[1] stays 0, rr_last=0 at the end.
- Contention: both ports valid continuously for 8 cycles after reset -> grants alternate 0,1,0,1,…, and each port receives 4 results tagged correctly.
- Full: DEPTH=4, shifter holds dout_valid=0 -> after 4 issues req_ready=0 and busy=1. Releasing one result allows the 5th issue on the following cycle, not the same cycle.
- Owner back-pressure: head belongs to port 1 with rsp_ready[1]=0 for 5 cycles -> sh_dout_ready=0 and rsp_valid[0]=0 throughout; the result is delivered when rsp_ready[1]=1.
- Protocol error: sh_dout_valid=1 with count=0 -> err=1 on the next cycle and remains 1 until reset.
- Mid-operation reset: 2 ops in flight, reset pulsed asynchronously between edges -> busy=0 and err=0 immediately, and port 0 wins the first grant when both ports request afterwards.
